// File: rtl/uart_rx.sv
// 8N1 serial receiver with input synchronizer, mid-bit sampling FSM and a small
// valid/ready receive FIFO.
`timescale 1ns/1ps
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_ASIZE   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_uart_rx,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned Depth = 1 << FIFO_ASIZE;
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    logic rx_meta, rx_s, rx_q, fall;
    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0] bitidx_q, bitidx_d;
    logic [7:0] shift_q, shift_d;
    logic push_req, frame_err_d, overrun_d;
    logic frame_err_q, overrun_q, busy_q;

    logic [FIFO_ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0] mem [Depth];
    logic [7:0] rdata_q, rdata_d;
    logic empty, full, pop, push;

    // Synchronizer resets to the idle-high level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    assign fall = rx_q & ~rx_s;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        bitidx_d    = bitidx_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d    = '0;
                    bitidx_d = '0;
                    state_d  = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d            = '0;
                    shift_d[bitidx_q] = rx_s;
                    bitidx_d         = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                // Start detection is suppressed until the line returns high (break).
                cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_ASIZE] != rptr_q[FIFO_ASIZE]) &&
                   (wptr_q[FIFO_ASIZE-1:0] == rptr_q[FIFO_ASIZE-1:0]);
    assign pop   = ~empty & rready;
    assign push  = push_req & (~full | pop);
    assign overrun_d = push_req & full & ~pop;

    always_comb begin
        wptr_d = wptr_q + (FIFO_ASIZE + 1)'(push);
        rptr_d = rptr_q + (FIFO_ASIZE + 1)'(pop);
        // New head is the byte being written this cycle when the FIFO was (or becomes) empty.
        if (rptr_d == wptr_q) rdata_d = shift_q;
        else                  rdata_d = mem[rptr_d[FIFO_ASIZE-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[FIFO_ASIZE-1:0]] <= shift_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitidx_q    <= bitidx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= (state_d != StIdle);
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = ~empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven in real time against a byte-queue model of the
// receiver (FIFO order, depth-limited overrun, framing errors).
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int unsigned Depth = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, tx, sel, rready;
    logic line_a, line_b, rready_a, rready_b;
    logic [7:0] rdata_a, rdata_b, rdata_m;
    logic rvalid_a, rvalid_b, rvalid_m;
    logic frame_err_a, frame_err_b, overrun_a, overrun_b, busy_a, busy_b, busy_m;

    assign line_a   = sel ? 1'b1 : tx;
    assign line_b   = sel ? tx : 1'b1;
    assign rready_a = rready & ~sel;
    assign rready_b = rready & sel;
    assign rdata_m  = sel ? rdata_b : rdata_a;
    assign rvalid_m = sel ? rvalid_b : rvalid_a;
    assign busy_m   = sel ? busy_b : busy_a;

    uart_rx #(.CLKS_PER_BIT(8), .FIFO_ASIZE(2)) dut_a (
        .clk(clk), .resetn(resetn), .i_uart_rx(line_a), .rdata(rdata_a), .rvalid(rvalid_a),
        .rready(rready_a), .frame_err(frame_err_a), .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx #(.CLKS_PER_BIT(434), .FIFO_ASIZE(2)) dut_b (
        .clk(clk), .resetn(resetn), .i_uart_rx(line_b), .rdata(rdata_b), .rvalid(rvalid_b),
        .rready(rready_b), .frame_err(frame_err_b), .overrun(overrun_b), .busy(busy_b)
    );

    int n_tests = 0, n_fail = 0;
    int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0, ov_before;
    real bit_ns;
    logic [7:0] q[$];

    always @(negedge clk) begin
        if (frame_err_a || frame_err_b) fe_cnt++;
        if (overrun_a || overrun_b) ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        tx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            tx = b[i];
            #(bit_ns);
        end
        tx = stop;
        #(bit_ns);
    endtask

    // Good frame: lands in the FIFO unless it already holds Depth bytes.
    task automatic send_m(input logic [7:0] b);
        send(b, 1'b1);
        if (q.size() == Depth) exp_ov++;
        else q.push_back(b);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        @(negedge clk);
        e = q.pop_front();
        check({tag, " rvalid"}, 32'(rvalid_m), 32'd1);
        check({tag, " rdata"}, 32'(rdata_m), 32'(e));
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (4) @(posedge clk);
        while (q.size() > 0) pop_check(tag);
        @(negedge clk);
        check({tag, " empty"}, 32'(rvalid_m), 32'd0);
        check({tag, " overruns"}, ov_cnt, exp_ov);
        check({tag, " frame errors"}, fe_cnt, exp_fe);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish within 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; tx = 1'b1; sel = 1'b0; rready = 1'b0; bit_ns = 80.0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rvalid", 32'(rvalid_a), 32'd0);
        check("reset rdata", 32'(rdata_a), 32'd0);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset frame_err", 32'(frame_err_a), 32'd0);
        check("reset overrun", 32'(overrun_a), 32'd0);
        resetn = 1'b1;
        repeat (3) @(posedge clk);

        // Single byte, held until popped
        send_m(8'hA5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1 rvalid", 32'(rvalid_a), 32'd1);
        check("t1 rdata", 32'(rdata_a), 32'hA5);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t1 hold", 32'(rdata_a), 32'hA5);
        drain("t1");

        // Back-to-back frames, fixed then random
        send_m(8'h00); send_m(8'hFF); send_m(8'h3C);
        drain("t2");
        for (int k = 0; k < 3; k++) send_m(8'($urandom));
        drain("t2 rnd");

        // Overrun on the fifth byte
        ov_before = ov_cnt;
        for (int k = 1; k <= 5; k++) send_m(8'(k));
        repeat (4) @(posedge clk);
        check("t3 overrun once", ov_cnt - ov_before, 1);
        drain("t3");

        // Full FIFO, pop in the stop-sample cycle of the next byte
        for (int k = 1; k <= 4; k++) send_m(8'(k));
        @(negedge clk);
        check("t4 head", 32'(rdata_a), 32'(q[0]));
        @(posedge clk);
        #1;
        fork
            send(8'h55, 1'b1);
            begin
                repeat (78) @(posedge clk);
                #1 rready = 1'b1;
                @(posedge clk);
                #1 rready = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(8'h55);
        drain("t4");

        // Framing error followed by a long break
        send(8'h7E, 1'b0);
        exp_fe++;
        #(30 * bit_ns);
        tx = 1'b1;
        #(2 * bit_ns);
        @(negedge clk);
        check("t5 frame_err once", fe_cnt, exp_fe);
        check("t5 no push", 32'(rvalid_a), 32'd0);
        send_m(8'h42);
        drain("t5");

        // Two-cycle glitch while idle
        @(posedge clk);
        #1 tx = 1'b0;
        #20 tx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t5 glitch busy", 32'(busy_a), 32'd0);
        check("t5 glitch no push", 32'(rvalid_a), 32'd0);
        check("t5 glitch no error", fe_cnt, exp_fe);

        // Async reset during bit 4 with two bytes buffered
        send_m(8'($urandom)); send_m(8'($urandom));
        repeat (4) @(posedge clk);
        @(posedge clk);
        #1;
        fork
            send(8'hC3, 1'b1);
            begin
                repeat (43) @(posedge clk);
                #1;
                check("t6 busy before reset", 32'(busy_a), 32'd1);
                resetn = 1'b0;
                #1;
                check("t6 rvalid in reset", 32'(rvalid_a), 32'd0);
                check("t6 busy in reset", 32'(busy_a), 32'd0);
            end
        join
        q.delete();
        repeat (2) @(posedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        send_m(8'h99);
        drain("t6");

        // Baud tolerance: 2% slow, 2% fast, then CLKS_PER_BIT=434
        bit_ns = 81.6;
        send_m(8'h00); send_m(8'hFF); send_m(8'h3C);
        drain("t6 slow");
        bit_ns = 78.4;
        send_m(8'h00); send_m(8'hFF); send_m(8'h3C);
        drain("t6 fast");
        sel = 1'b1;
        bit_ns = 4340.0;
        repeat (3) @(posedge clk);
        send_m(8'h00); send_m(8'hFF); send_m(8'($urandom));
        drain("t6 cpb434");
        check("t6 cpb434 idle", 32'(busy_m), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1, LSB first, idle-high line. Counterpart of the debug UART transmitter.
- Takes the host-PC TXD pin, recovers bytes, and buffers them in a small FIFO with a valid/ready read interface.
- Consumers are GPU debug and control logic, for example scene or camera commands from the host.
- Runs in the 50 MHz sd_clk/UART domain. One clock, no CDC apart from the input pin synchronizer.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per bit period (50 MHz / 115200). Must be ≥ 4.
- FIFO_ASIZE, 4: receive FIFO depth = 2^FIFO_ASIZE bytes.

Ports:
- clk  in  1  receiver clock.
- resetn  in  1  asynchronous, active-low reset.
- i_uart_rx  in  1  raw serial input pin, asynchronous to clk.
- rdata  out  8  head-of-FIFO byte; valid only while rvalid=1.
- rvalid  out  1  FIFO non-empty.
- rready  in  1  consumer pop; a pop occurs when rvalid & rready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:

Reset (resetn=0, async):
- FSM goes to IDLE. FIFO is emptied (rd/wr pointers = 0).
- rvalid=0, rdata=0, frame_err=0, overrun=0, busy=0.
- Synchronizer flops are set to 1 (line idle).
- Reset in mid-frame abandons the partial byte. After release, the receiver needs the line high for 1 cycle before it accepts a new start.

Input synchronizer and edge detect:
- Two flops synchronize i_uart_rx to rx_s. A third flop holds rx_q.
- Falling edge = rx_q & ~rx_s.
- All sampling uses rx_s. This adds 2 cycles of pin-to-FSM latency.

Bit counter:
- cnt counts 0..CLKS_PER_BIT-1.
- bitidx counts 0..7.

FSM states:
- IDLE: on a falling edge → START, cnt=0.
- START: when cnt = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
  - rx_s=1 means a glitch: return to IDLE, no output.
  - rx_s=0: go to DATA with cnt=0, bitidx=0.
- DATA: when cnt = CLKS_PER_BIT-1, sample rx_s into shift[bitidx] (LSB first) and reset cnt=0.
  - After bitidx=7, go to STOP.
- STOP: when cnt = CLKS_PER_BIT-1, sample rx_s.
  - 1 = good byte: push it to the FIFO, or pulse overrun if the FIFO is full and no pop occurs this cycle. Then go to IDLE.
  - 0 = framing error: pulse frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH (break/line-low handling): stay until rx_s=1, then go to IDLE.
  - No start detection while here, so a held-low break produces exactly one frame_err.

Sample timing:
- Every sample lands at mid-bit ±1 cycle.
- Data bit n is sampled (CLKS_PER_BIT/2) + (n+1)·CLKS_PER_BIT cycles after the synchronized falling edge.
- The stop bit is sampled at (CLKS_PER_BIT/2) + 9·CLKS_PER_BIT cycles after that edge.
- Receiver returns to IDLE half a bit early, which tolerates ±2% baud mismatch and back-to-back frames.

FIFO:
- Synchronous, registered rdata.
- Write pointer and read pointer are FIFO_ASIZE+1 bits wide.
- full = MSBs differ and LSBs are equal. empty = pointers equal.
- A byte pushed at cycle T gives rvalid=1 and rdata=byte at T+1 if the FIFO was empty.
- A pop at T presents the next entry at T+1, or deasserts rvalid if the FIFO is now empty.
- Push and pop in the same cycle:
  - Both succeed, even when full. The pop frees a slot for the push.
  - When empty, only the push takes effect because there is no valid data to pop.
- rready while rvalid=0 is ignored.
- Pointers wrap modulo 2^(FIFO_ASIZE+1). Ordering is preserved across the wrap.

Pulses:
- frame_err and overrun are single-cycle, registered, and mutually exclusive within a frame.

busy:
- busy = (state != IDLE), registered with the state.

Test Plan (CLKS_PER_BIT=8, FIFO_ASIZE=2 unless noted):
1. Single byte: drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with rready=0 → rvalid rises once and rdata=8'hA5, held stable. Pulse rready for 1 cycle → rvalid=0 on the next cycle.
2. Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap, rready=0 → FIFO holds 3 entries. Popping gives 00, FF, 3C in order. frame_err and overrun stay 0.
3. Overrun: send 5 bytes 0x01..0x05 with rready=0 (depth 4) → overrun pulses exactly once, at stop of 0x05. The FIFO then reads 01, 02, 03, 04.
4. Full with simultaneous pop: FIFO full, assert rready in the exact stop-sample cycle of a 5th byte 0x55 → no overrun. Subsequent reads give 02, 03, 04, 55.
5. Framing and break cases:
   - Frame 0x7E with stop=0 → frame_err pulses once and nothing is pushed.
   - Then hold the line low for 30 bit times → no further frame_err.
   - Release the line high and send 0x42 → rdata=0x42.
   - Glitch: a low pulse of 2 cycles while IDLE → the FSM returns to IDLE from START with no push and no error.
6. Async reset and baud tolerance:
   - Assert resetn=0 during bit 4 of a frame, with the FIFO holding 2 bytes → rvalid=0 and busy=0 immediately. After release, send 0x99 → it is received correctly.
   - Repeat test 2 with the line driven at 2% fast and 2% slow baud, and at CLKS_PER_BIT=434 → all bytes match.
